benes_cfg_loader: RTL and testbench

- Sits directly upstream of the Benes network datapath. Drives its per-stage switch_set array.
- Receives switch settings as a valid/ready stream, one stage word per beat, into a shadow bank.
- Validates the frame length, then swaps the shadow bank into the active bank on a commit pulse.
- The network sees glitch-free, registered settings that change only on commit.

---
 rtl/benes_cfg_loader_pkg.sv | 22 ++
 rtl/benes_cfg_loader_if.sv | 32 +++
 rtl/benes_cfg_loader.sv | 101 ++++++++++
 tb/tb_benes_cfg_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/benes_cfg_loader_pkg.sv
// Shared sizes and types for the Benes network configuration loader.
// Shared by the loader, its stream interface and the testbench.
package benes_cfg_loader_pkg;

    localparam int SIZE       = 32;
    localparam int SWITCH_NUM = SIZE / 2;
    localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1;
    localparam int DATA_WIDTH = SIZE;
    localparam int CNT_W      = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        FULL
    } cfg_state_t;

    function automatic logic even_par(input logic [SWITCH_NUM-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/benes_cfg_loader_if.sv
// Valid/ready stream carrying one stage word of switch settings per beat.
// Optional cfg_parity wire exists only when BENES_CFG_PARITY_EN is defined.
interface benes_cfg_loader_if;
    import benes_cfg_loader_pkg::*;

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [SWITCH_NUM-1:0] cfg_data;
    logic                  cfg_last;
`ifdef BENES_CFG_PARITY_EN
    logic                  cfg_parity;

    modport master (
        output cfg_valid, cfg_data, cfg_last, cfg_parity,
        input  cfg_ready
    );
    modport slave (
        input  cfg_valid, cfg_data, cfg_last, cfg_parity,
        output cfg_ready
    );
`else
    modport master (
        output cfg_valid, cfg_data, cfg_last,
        input  cfg_ready
    );
    modport slave (
        input  cfg_valid, cfg_data, cfg_last,
        output cfg_ready
    );
`endif

endinterface

// File: rtl/benes_cfg_loader.sv
// Shadow/active configuration banks for the Benes switch array.
// Define BENES_CFG_PARITY_EN to add per-beat even-parity checking.
module benes_cfg_loader
    import benes_cfg_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    benes_cfg_loader_if.slave     cfg,
    input  logic                  commit,
    output logic [SWITCH_NUM-1:0] switch_set [0:STAGE_NUM-1],
    output logic                  cfg_full,
    output logic                  commit_done,
    output logic                  cfg_err
);

    cfg_state_t            state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [SWITCH_NUM-1:0] shadow [0:STAGE_NUM-1];
    logic                  acc, at_end, par_bad;
    logic                  we, swap, err_d;

    assign cfg.cfg_ready = !rst && (state != FULL);
    assign cfg_full      = (state == FULL);
    assign acc           = cfg.cfg_valid && cfg.cfg_ready;
    assign at_end        = (cnt == CNT_W'(STAGE_NUM - 1));

`ifdef BENES_CFG_PARITY_EN
    assign par_bad = (cfg.cfg_parity != even_par(cfg.cfg_data));
`else
    assign par_bad = 1'b0;
`endif

    // IDLE is LOAD with cnt==0, so both share the frame-length rules
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        we      = 1'b0;
        swap    = 1'b0;
        err_d   = 1'b0;
        unique case (state)
            IDLE, LOAD: begin
                if (acc) begin
                    we = 1'b1;
                    if (par_bad) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = cfg.cfg_last ? IDLE : DRAIN;
                    end else if (cfg.cfg_last) begin
                        cnt_d   = '0;
                        state_d = at_end ? FULL : IDLE;
                        err_d   = !at_end;
                    end else if (at_end) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d   = cnt + CNT_W'(1);
                        state_d = LOAD;
                    end
                end
            end
            DRAIN: begin
                if (acc && cfg.cfg_last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            FULL: begin
                if (commit) begin
                    swap    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cfg_err     <= 1'b0;
            commit_done <= 1'b0;
            for (int i = 0; i < STAGE_NUM; i++) begin
                shadow[i]     <= '0;
                switch_set[i] <= '0;
            end
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            cfg_err     <= err_d;
            commit_done <= swap;
            if (we) shadow[cnt] <= cfg.cfg_data;
            if (swap) begin
                for (int i = 0; i < STAGE_NUM; i++)
                    switch_set[i] <= shadow[i];
            end
        end
    end

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Self-checking bench for benes_cfg_loader: vector table, directed corner
// sequences and random traffic against a frame-level reference model.
module tb_benes_cfg_loader;
    import benes_cfg_loader_pkg::*;

    localparam int W = SWITCH_NUM;
    localparam int N = STAGE_NUM;

    logic         clk = 1'b0;
    logic         rst;
    logic         commit;
    logic [W-1:0] sw [0:N-1];
    logic         cfg_full, commit_done, cfg_err;

    benes_cfg_loader_if bus();

    benes_cfg_loader dut (
        .clk         (clk),
        .rst         (rst),
        .cfg         (bus.slave),
        .commit      (commit),
        .switch_set  (sw),
        .cfg_full    (cfg_full),
        .commit_done (commit_done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // frame-level reference model
    logic [W-1:0] m_q [$];
    logic [W-1:0] m_shadow [0:N-1];
    logic [W-1:0] m_active [0:N-1];
    bit           m_full, m_drain, m_err, m_done;

    typedef struct {
        bit           v;
        logic [W-1:0] d;
        bit           l;
        bit           c;
        bit           e_rdy;
        bit           e_full;
        bit           e_err;
        bit           e_done;
    } vec_t;

    vec_t tbl [0:N+1];

    task automatic chk(input string nm, input logic [N*W-1:0] act,
                       input logic [N*W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] flat_dut();
        logic [N*W-1:0] f;
        for (int k = 0; k < N; k++) f[k*W +: W] = sw[k];
        return f;
    endfunction

    function automatic logic [N*W-1:0] flat_model();
        logic [N*W-1:0] f;
        for (int k = 0; k < N; k++) f[k*W +: W] = m_active[k];
        return f;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_full  = 0;
        m_drain = 0;
        m_err   = 0;
        m_done  = 0;
        for (int k = 0; k < N; k++) begin
            m_shadow[k] = '0;
            m_active[k] = '0;
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".ready"}, N*W'(bus.cfg_ready), N*W'(!m_full));
        chk({tag, ".full"},  N*W'(cfg_full),      N*W'(m_full));
        chk({tag, ".err"},   N*W'(cfg_err),       N*W'(m_err));
        chk({tag, ".done"},  N*W'(commit_done),   N*W'(m_done));
        chk({tag, ".sw"},    flat_dut(),          flat_model());
    endtask

    // one clock: drive, advance model across the edge, compare
    task automatic cyc(input bit v, input logic [W-1:0] d, input bit l,
                       input bit c, input string tag);
        bit acc, com;
        bus.cfg_valid = v;
        bus.cfg_data  = d;
        bus.cfg_last  = l;
`ifdef BENES_CFG_PARITY_EN
        bus.cfg_parity = ^d;
`endif
        commit = c;
        acc = v && !m_full;
        com = c && m_full;
        @(posedge clk);
        #1;
        m_err  = 0;
        m_done = 0;
        if (com) begin
            for (int k = 0; k < N; k++) m_active[k] = m_shadow[k];
            m_full = 0;
            m_done = 1;
        end
        if (acc) begin
            if (m_drain) begin
                if (l) m_drain = 0;
            end else begin
                m_q.push_back(d);
                if (l) begin
                    if (m_q.size() == N) begin
                        for (int k = 0; k < N; k++) m_shadow[k] = m_q[k];
                        m_full = 1;
                    end else begin
                        m_err = 1;
                    end
                    m_q.delete();
                end else if (m_q.size() == N) begin
                    m_err   = 1;
                    m_drain = 1;
                    m_q.delete();
                end
            end
        end
        check_outs(tag);
    endtask

    task automatic frame(input logic [W-1:0] d, input bit c, input string tag);
        for (int k = 0; k < N; k++) cyc(1, d, k == N - 1, c, tag);
    endtask

    logic [N*W-1:0] exp_f;

    initial begin
        bus.cfg_valid = 0;
        bus.cfg_data  = '0;
        bus.cfg_last  = 0;
`ifdef BENES_CFG_PARITY_EN
        bus.cfg_parity = 0;
`endif
        commit = 0;
        rst    = 1;
        model_reset();
        #12;
        chk("rst.ready", N*W'(bus.cfg_ready), '0);
        chk("rst.full",  N*W'(cfg_full), '0);
        chk("rst.sw",    flat_dut(), '0);
        @(posedge clk);
        #3 rst = 0;
        #1;
        chk("rel.ready", N*W'(bus.cfg_ready), N*W'(1));

        // vector table: stage-index frame, then commit
        for (int k = 0; k < N; k++)
            tbl[k] = '{1, W'(k), k == N - 1, 0, k < N - 1, k == N - 1, 0, 0};
        tbl[N]   = '{0, '0, 0, 1, 1, 0, 0, 1};
        tbl[N+1] = '{0, '0, 0, 0, 1, 0, 0, 0};
        for (int i = 0; i < N + 2; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].c, "tbl");
            chk("tbl.ready", N*W'(bus.cfg_ready), N*W'(tbl[i].e_rdy));
            chk("tbl.full",  N*W'(cfg_full),      N*W'(tbl[i].e_full));
            chk("tbl.err",   N*W'(cfg_err),       N*W'(tbl[i].e_err));
            chk("tbl.done",  N*W'(commit_done),   N*W'(tbl[i].e_done));
        end
        for (int k = 0; k < N; k++) exp_f[k*W +: W] = W'(k);
        chk("tbl.sw_index", flat_dut(), exp_f);

        // short frame, then a good one
        for (int k = 0; k < 5; k++) cyc(1, 16'h1111, k == 4, 0, "short");
        chk("short.err", N*W'(cfg_err), N*W'(1));
        cyc(0, '0, 0, 1, "short.ign");
        frame(16'h3C3C, 0, "short.ok");
        cyc(0, '0, 0, 1, "short.commit");

        // long frame: error on the last stage beat only, rest drained
        for (int k = 0; k < 11; k++) cyc(1, 16'hFFFF, k == 10, 0, "long");
        cyc(0, '0, 0, 1, "long.ign");

        // commit held through load: swap right after FULL
        frame(16'hA5A5, 1, "hold");
        cyc(0, '0, 0, 1, "hold.swap");
        for (int k = 0; k < N; k++) exp_f[k*W +: W] = 16'hA5A5;
        chk("hold.sw", flat_dut(), exp_f);
        cyc(0, '0, 0, 1, "hold.idle");

        // back-pressure while FULL; pending beat becomes stage 0
        frame(16'h0F0F, 0, "bp");
        for (int k = 0; k < 4; k++) cyc(1, 16'hBEEF, 0, 0, "bp.wait");
        cyc(1, 16'hBEEF, 0, 1, "bp.commit");
        for (int k = 0; k < N; k++) exp_f[k*W +: W] = 16'h0F0F;
        chk("bp.sw", flat_dut(), exp_f);
        cyc(1, 16'hBEEF, 0, 0, "bp.s0");
        for (int k = 1; k < N; k++) cyc(1, W'(k), k == N - 1, 0, "bp.rest");
        cyc(0, '0, 0, 1, "bp.swap");
        chk("bp.sw0", N*W'(sw[0]), N*W'(16'hBEEF));

        // async reset in the middle of a frame
        for (int k = 0; k < 4; k++) cyc(1, 16'h7777, 0, 0, "arst");
        #2 rst = 1;
        #1;
        model_reset();
        chk("arst.sw",   flat_dut(), '0);
        chk("arst.full", N*W'(cfg_full), '0);
        chk("arst.ready", N*W'(bus.cfg_ready), '0);
        @(posedge clk);
        #3 rst = 0;
        frame(16'h5A5A, 0, "arst.frame");
        cyc(0, '0, 0, 1, "arst.swap");
        chk("arst.sw0", N*W'(sw[0]), N*W'(16'h5A5A));

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit v, l, c;
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 11) == 0) ||
                (m_q.size() == N - 1 && $urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 9) < 3);
            cyc(v, W'($urandom), l, c, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
